// File: rtl/noc_ni_buffered_pkg.sv
// Shared definitions for the buffered mesh network interface.
// Header field placement, address width and TX FSM encoding.
package noc_ni_buffered_pkg;

  localparam int MESH_AW = 4;

  localparam int DEST_SLOT = 1;
  localparam int SRC_SLOT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } tx_state_e;

  function automatic int field_lsb(
    input int flit_w,
    input int slot
  );
    return flit_w - slot * MESH_AW;
  endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// Synchronous FIFO used for both NI directions.
// Registered head, no fall-through; full blocks push even with a pop.
module noc_ni_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem[rd_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; wrap comes from natural overflow of the extra bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_ni_buffered.sv
// Buffered PE<->switch network interface.
// TX: stop-and-wait with timeout/retry. RX: address filter and ack.
module noc_ni_buffered
  import noc_ni_buffered_pkg::*;
#(
  parameter logic [MESH_AW-1:0] ADDR      = 4'b0000,
  parameter int                 FLIT_W    = 32,
  parameter int                 TX_DEPTH  = 4,
  parameter int                 RX_DEPTH  = 4,
  parameter logic [9:0]         TIMEOUT   = 10'd50,
  parameter int                 MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] pe_tx_flit,
  input  logic              pe_tx_valid,
  output logic              pe_tx_ready,
  output logic [FLIT_W-1:0] sw_tx_flit,
  output logic              sw_tx_req,
  input  logic              sw_tx_grant,
  input  logic              sw_tx_ack,
  input  logic [FLIT_W-1:0] sw_rx_flit,
  input  logic              sw_rx_valid,
  output logic              sw_rx_ack,
  output logic [FLIT_W-1:0] pe_rx_flit,
  output logic              pe_rx_valid,
  input  logic              pe_rx_ready,
  output logic              timeout,
  output logic              tx_fail,
  output logic [7:0]        drop_cnt
);

  localparam int DEST_LSB = field_lsb(FLIT_W, DEST_SLOT);
  localparam int SRC_LSB  = field_lsb(FLIT_W, SRC_SLOT);
  localparam int RW = (MAX_RETRY < 1) ? 1
                    : $clog2(MAX_RETRY + 1);

  logic [FLIT_W-1:0] tx_in;
  logic [FLIT_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;

  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_drop;
  logic              dest_ok;

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [9:0]        timer_q;
  logic [RW-1:0]     retry_q;
  logic [FLIT_W-1:0] flit_q;
  logic              ack_q;
  logic [7:0]        drop_q;
  logic              expire;
  logic              give_up;

  // Source stamping happens on the way into the TX FIFO.
  always_comb begin
    tx_in = pe_tx_flit;
    tx_in[SRC_LSB +: MESH_AW] = ADDR;
  end

  assign pe_tx_ready = !tx_full;
  assign tx_push     = pe_tx_valid && !tx_full;

  noc_ni_fifo #(
    .W     (FLIT_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_in),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign expire  = (state_q == ST_WAIT_ACK) && !sw_tx_ack &&
                   (timer_q == TIMEOUT - 10'd1);
  assign give_up = expire && !(retry_q < RW'(MAX_RETRY));

  // TX FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // TX FSM next-state logic; an ack beats a same-cycle expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!tx_empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (sw_tx_grant) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (sw_tx_ack)   state_d = ST_IDLE;
        else if (expire) state_d = give_up ? ST_IDLE : ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // TX FSM outputs.
  always_comb begin
    sw_tx_req = (state_q == ST_REQ);
    timeout   = expire;
    tx_fail   = give_up;
    tx_pop    = ((state_q == ST_WAIT_ACK) && sw_tx_ack) ||
                give_up;
  end

  // Ack timer: restarts on every entry into WAIT_ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if ((state_q == ST_WAIT_ACK) &&
                 (state_d == ST_WAIT_ACK)) begin
      timer_q <= timer_q + 10'd1;
    end else begin
      timer_q <= '0;
    end
  end

  // Retry count for the flit in flight; cleared while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      retry_q <= '0;
    end else if (state_q == ST_IDLE) begin
      retry_q <= '0;
    end else if (expire && !give_up) begin
      retry_q <= retry_q + RW'(1);
    end
  end

  // Outgoing flit register: loaded on entry to REQ, zero in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_q <= '0;
    end else if (state_d == ST_IDLE) begin
      flit_q <= '0;
    end else if ((state_d == ST_REQ) &&
                 (state_q != ST_REQ)) begin
      flit_q <= tx_head;
    end
  end

  assign sw_tx_flit = flit_q;

  assign dest_ok = (sw_rx_flit[DEST_LSB +: MESH_AW] == ADDR);
  assign rx_push = sw_rx_valid && dest_ok && !rx_full;
  assign rx_drop = sw_rx_valid && !rx_push;
  assign rx_pop  = pe_rx_ready && !rx_empty;

  noc_ni_fifo #(
    .W     (FLIT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (sw_rx_flit),
    .head  (pe_rx_flit),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign pe_rx_valid = !rx_empty;

  // RX ack pulse one cycle after an accepted flit.
  always_ff @(posedge clk) begin
    if (reset) ack_q <= 1'b0;
    else       ack_q <= rx_push;
  end

  // Saturating count of misrouted or overflow drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (rx_drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign sw_rx_ack = ack_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_noc_ni_buffered.sv
// Randomized bench for noc_ni_buffered.
// Queue-based reference model of the NI protocol rules.
module tb_noc_ni_buffered;

  localparam logic [3:0] ADDR = 4'hA;
  localparam int TXD  = 4;
  localparam int RXD  = 4;
  localparam int TO   = 50;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pe_tx_flit;
  logic        pe_tx_valid;
  logic        pe_tx_ready;
  logic [31:0] sw_tx_flit;
  logic        sw_tx_req;
  logic        sw_tx_grant;
  logic        sw_tx_ack;
  logic [31:0] sw_rx_flit;
  logic        sw_rx_valid;
  logic        sw_rx_ack;
  logic [31:0] pe_rx_flit;
  logic        pe_rx_valid;
  logic        pe_rx_ready;
  logic        timeout;
  logic        tx_fail;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  noc_ni_buffered #(
    .ADDR      (ADDR),
    .FLIT_W    (32),
    .TX_DEPTH  (TXD),
    .RX_DEPTH  (RXD),
    .TIMEOUT   (10'd50),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pe_tx_flit  (pe_tx_flit),
    .pe_tx_valid (pe_tx_valid),
    .pe_tx_ready (pe_tx_ready),
    .sw_tx_flit  (sw_tx_flit),
    .sw_tx_req   (sw_tx_req),
    .sw_tx_grant (sw_tx_grant),
    .sw_tx_ack   (sw_tx_ack),
    .sw_rx_flit  (sw_rx_flit),
    .sw_rx_valid (sw_rx_valid),
    .sw_rx_ack   (sw_rx_ack),
    .pe_rx_flit  (pe_rx_flit),
    .pe_rx_valid (pe_rx_valid),
    .pe_rx_ready (pe_rx_ready),
    .timeout     (timeout),
    .tx_fail     (tx_fail),
    .drop_cnt    (drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, act, exp, $time);
    end
  endtask

  // Reference model: flits queued, link phase, attempt count.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit m_req;
  bit m_wait;
  bit m_ack;
  int m_age;
  int m_tries;
  int m_drop;
  int mode;
  bit rst_req;
  int n_fail_seen;
  int n_to_seen;

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_req   = 0;
    m_wait  = 0;
    m_ack   = 0;
    m_age   = 0;
    m_tries = 0;
    m_drop  = 0;
  endtask

  task automatic model_step();
    int n_tx;
    int n_rx;
    bit pop_tx;
    bit acc;
    logic [31:0] f;
    if (reset) begin
      model_clear();
      return;
    end
    n_tx   = txq.size();
    n_rx   = rxq.size();
    pop_tx = 0;
    if (m_wait) begin
      if (sw_tx_ack) begin
        pop_tx = 1;
        m_wait = 0;
      end else if (m_age == TO - 1) begin
        m_wait = 0;
        if (m_tries < MAXR) begin
          m_tries++;
          m_req = 1;
        end else begin
          pop_tx = 1;
        end
      end else begin
        m_age++;
      end
    end else if (m_req) begin
      if (sw_tx_grant) begin
        m_req  = 0;
        m_wait = 1;
        m_age  = 0;
      end
    end else if (n_tx > 0) begin
      m_req   = 1;
      m_tries = 0;
    end
    if (pop_tx) void'(txq.pop_front());
    if (pe_tx_valid && n_tx < TXD) begin
      f = pe_tx_flit;
      f[27:24] = ADDR;
      txq.push_back(f);
    end
    acc = sw_rx_valid && (sw_rx_flit[31:28] == ADDR) &&
          (n_rx < RXD);
    if (pe_rx_ready && n_rx > 0) void'(rxq.pop_front());
    if (acc) rxq.push_back(sw_rx_flit);
    m_ack = acc;
    if (sw_rx_valid && !acc && m_drop < 255) m_drop++;
  endtask

  task automatic check_outputs();
    bit exp_to;
    bit exp_fail;
    exp_to   = m_wait && !sw_tx_ack && (m_age == TO - 1);
    exp_fail = exp_to && (m_tries == MAXR);
    if (exp_to) n_to_seen++;
    if (exp_fail) n_fail_seen++;
    check("pe_tx_ready", pe_tx_ready, txq.size() < TXD);
    check("sw_tx_req", sw_tx_req, m_req);
    if (m_req)
      check("sw_tx_flit", sw_tx_flit, txq[0]);
    else if (!m_wait)
      check("sw_tx_flit_idle", sw_tx_flit, 0);
    check("timeout", timeout, exp_to);
    check("tx_fail", tx_fail, exp_fail);
    check("sw_rx_ack", sw_rx_ack, m_ack);
    check("pe_rx_valid", pe_rx_valid, rxq.size() > 0);
    if (rxq.size() > 0)
      check("pe_rx_flit", pe_rx_flit, rxq[0]);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  function automatic logic [31:0] rx_flit();
    logic [31:0] f;
    f = $urandom;
    if ($urandom_range(1, 0) == 1) f[31:28] = ADDR;
    return f;
  endfunction

  task automatic drive();
    reset       = rst_req;
    pe_tx_flit  = $urandom;
    sw_rx_flit  = rx_flit();
    pe_tx_valid = ($urandom_range(2, 0) == 0);
    sw_tx_grant = ($urandom_range(1, 0) == 1);
    sw_tx_ack   = ($urandom_range(7, 0) == 0);
    sw_rx_valid = ($urandom_range(2, 0) == 0);
    pe_rx_ready = ($urandom_range(1, 0) == 1);
    case (mode)
      1: sw_tx_ack = 0;
      2: begin
        sw_tx_grant = 1;
        sw_tx_ack   = m_wait && (m_age == TO - 1);
      end
      3: begin
        pe_tx_valid = 1;
        sw_tx_grant = 0;
        sw_tx_ack   = 0;
        sw_rx_valid = 1;
        pe_rx_ready = 0;
      end
      4: begin
        pe_tx_valid = 0;
        sw_tx_ack   = 1;
        sw_rx_valid = 0;
      end
      5: begin
        pe_tx_valid = 1;
        sw_tx_grant = 1;
        sw_tx_ack   = 0;
        sw_rx_valid = 1;
        sw_rx_flit[31:28] = ADDR;
        pe_rx_ready = 0;
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit found;
    n_fail_seen = 0;
    n_to_seen   = 0;
    rst_req     = 1;
    reset       = 1;
    pe_tx_flit  = '0;
    pe_tx_valid = 0;
    sw_tx_grant = 0;
    sw_tx_ack   = 0;
    sw_rx_flit  = '0;
    sw_rx_valid = 0;
    pe_rx_ready = 0;
    mode        = 0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    check("rst_pe_tx_ready", pe_tx_ready, 1);
    check("rst_sw_tx_req", sw_tx_req, 0);
    check("rst_sw_tx_flit", sw_tx_flit, 0);
    check("rst_pe_rx_valid", pe_rx_valid, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst_req = 0;

    run(3, 300);
    run(0, 400);
    run(1, 500);
    run(2, 300);
    run(0, 200);

    mode  = 5;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      found = m_wait && (txq.size() >= 3) &&
              (rxq.size() >= 2);
    end
    check("reset_window_found", found, 1);
    rst_req = 1;
    cycle();
    rst_req = 0;
    @(negedge clk);
    #1;
    check("mid_rst_req", sw_tx_req, 0);
    check("mid_rst_flit", sw_tx_flit, 0);
    check("mid_rst_rx_valid", pe_rx_valid, 0);
    check("mid_rst_tx_ready", pe_tx_ready, 1);
    @(posedge clk);
    model_step();
    run(4, 20);
    run(0, 200);

    check("saw_timeouts", n_to_seen > 0, 1);
    check("saw_tx_fail", n_fail_seen > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
